// File: rtl/cnt16_ctrl.sv
// cnt16_ctrl: run controller with embedded counter, pass counting, wrap/done pulses
module cnt16_ctrl #(
    parameter int CNT_W = 4,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [CNT_W-1:0] term,
    input  logic [REP_W-1:0] reps,
    output logic [CNT_W-1:0] cnt,
    output logic             busy,
    output logic             wrap,
    output logic             done,
    output logic [REP_W-1:0] pass
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt_nx, term_q, term_nx;
    logic [REP_W-1:0] pass_nx, reps_q, reps_nx, pass_inc;
    logic wrap_nx, done_nx, at_term;
    assign pass_inc = pass + REP_W'(1);
    assign at_term  = cnt == term_q;
    // next state and next register values; stop dominates everything while busy
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pass_nx  = pass;
        term_nx  = term_q;
        reps_nx  = reps_q;
        wrap_nx  = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE: if (start && !stop) begin
                state_nx = RUN;
                term_nx  = term;
                reps_nx  = reps;
                cnt_nx   = '0;
                pass_nx  = '0;
            end
            RUN: if (stop) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end else if (pause) begin
                state_nx = HOLD;
            end else if (at_term) begin
                cnt_nx  = '0;
                wrap_nx = 1'b1;
                pass_nx = pass_inc;
                if (reps_q != '0 && pass_inc == reps_q) begin
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end else begin
                cnt_nx = cnt + CNT_W'(1);
            end
            HOLD: if (stop) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end else if (!pause) begin
                state_nx = RUN;
            end
            default: state_nx = IDLE;
        endcase
    end
    // register state, latched run parameters and all outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            pass   <= '0;
            term_q <= '0;
            reps_q <= '0;
            busy   <= 1'b0;
            wrap   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            pass   <= pass_nx;
            term_q <= term_nx;
            reps_q <= reps_nx;
            busy   <= state_nx != IDLE;
            wrap   <= wrap_nx;
            done   <= done_nx;
        end
    end
endmodule

// File: tb/tb_cnt16_ctrl.sv
// tb_cnt16_ctrl: directed self-checking bench for cnt16_ctrl
module tb_cnt16_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] term = '0;
    logic [3:0] reps = '0;
    logic [3:0] cnt;
    logic       busy, wrap, done;
    logic [3:0] pass;
    int n_chk = 0;
    int n_ok = 0;

    cnt16_ctrl #(.CNT_W(4), .REP_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
        .term(term), .reps(reps), .cnt(cnt), .busy(busy), .wrap(wrap),
        .done(done), .pass(pass)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_ok++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input int c, input int b, input int w, input int d, input int p);
        chk({tag, " cnt"}, cnt, c);
        chk({tag, " busy"}, busy, b);
        chk({tag, " wrap"}, wrap, w);
        chk({tag, " done"}, done, d);
        chk({tag, " pass"}, pass, p);
    endtask

    int fin_cnt[8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    int pau_cnt[10] = '{1, 2, 2, 2, 2, 2, 3, 4, 5, 0};

    initial begin
        #1;
        outs("reset", 0, 0, 0, 0, 0);
        tick();
        @(negedge clk) rst_n = 1'b1;
        tick();
        outs("idle_after_reset", 0, 0, 0, 0, 0);

        // finite run term=3 reps=2, with an ignored start (term=9) mid-run
        term = 4'd3; reps = 4'd2; start = 1'b1;
        tick();
        outs("fin_accept", 0, 1, 0, 0, 0);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            outs($sformatf("fin_e%0d", i + 1), fin_cnt[i], i == 7 ? 0 : 1,
                 (i == 3 || i == 7) ? 1 : 0, i == 7 ? 1 : 0, i < 3 ? 0 : (i < 7 ? 1 : 2));
            if (i == 0) begin start = 1'b1; term = 4'd9; reps = 4'd5; end
            if (i == 1) start = 1'b0;
        end
        tick();
        outs("fin_after", 0, 0, 0, 0, 2);

        // pause for 3 cycles at cnt=2, term=5 reps=1
        term = 4'd5; reps = 4'd1; start = 1'b1;
        tick();
        outs("pau_accept", 0, 1, 0, 0, 0);
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            outs($sformatf("pau_e%0d", i + 1), pau_cnt[i], i == 9 ? 0 : 1,
                 i == 9 ? 1 : 0, i == 9 ? 1 : 0, i == 9 ? 1 : 0);
            if (i == 1) pause = 1'b1;
            if (i == 4) pause = 1'b0;
        end

        // stop at cnt=4 pass=1, endless run term=7
        term = 4'd7; reps = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        outs("stop_before", 4, 1, 0, 0, 1);
        stop = 1'b1;
        tick();
        outs("stop_edge", 0, 0, 0, 0, 1);
        stop = 1'b0;
        tick();
        outs("stop_after", 0, 0, 0, 0, 1);

        // start and stop together from IDLE
        term = 4'd3; reps = 4'd1; start = 1'b1; stop = 1'b1;
        tick();
        outs("collide", 0, 0, 0, 0, 1);
        start = 1'b0; stop = 1'b0;
        tick();
        outs("collide_after", 0, 0, 0, 0, 1);

        // term=0 reps=1: one counting edge then wrap+done
        term = 4'd0; reps = 4'd1; start = 1'b1;
        tick();
        outs("t0r1_accept", 0, 1, 0, 0, 0);
        start = 1'b0;
        tick();
        outs("t0r1_done", 0, 0, 1, 1, 1);
        tick();
        outs("t0r1_after", 0, 0, 0, 0, 1);

        // endless term=0: wrap every edge, pass rolls 15->0, never done
        term = 4'd0; reps = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            outs($sformatf("endless_e%0d", i + 1), 0, 1, 1, 0, (i + 1) % 16);
        end
        stop = 1'b1;
        tick();
        outs("endless_stop", 0, 0, 0, 0, 4);
        stop = 1'b0;

        // asynchronous reset in the middle of a run
        term = 4'd7; reps = 4'd0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        outs("rst_pre", 3, 1, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        outs("rst_async", 0, 0, 0, 0, 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        outs("rst_release", 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_ok, n_chk);
        $finish;
    end
endmodule
